// File: rtl/error_frame_sequencer_if.sv
// error_frame_sequencer_if: bit-level bus between the CAN error/overload detection logic and
// the error frame sequencer.
//   Inputs to the sequencer : rxBit, isTransmitter, stuffErro/crcErro/eofErro/bitErro
//                             (active-low), overloadFlag, frameOk
//   Outputs of the sequencer: txBit, erroFrame, overloadFrame, interframe, tec[8:0], rec[7:0],
//                             errorPassive, busOff
// master = sequencer side, slave = detection/bench side.
interface error_frame_sequencer_if;
  logic       rxBit;
  logic       isTransmitter;
  logic       stuffErro;
  logic       crcErro;
  logic       eofErro;
  logic       bitErro;
  logic       overloadFlag;
  logic       frameOk;
  logic       txBit;
  logic       erroFrame;
  logic       overloadFrame;
  logic       interframe;
  logic [8:0] tec;
  logic [7:0] rec;
  logic       errorPassive;
  logic       busOff;

  modport master (
    input  rxBit, isTransmitter, stuffErro, crcErro, eofErro, bitErro, overloadFlag, frameOk,
    output txBit, erroFrame, overloadFrame, interframe, tec, rec, errorPassive, busOff
  );

  modport slave (
    output rxBit, isTransmitter, stuffErro, crcErro, eofErro, bitErro, overloadFlag, frameOk,
    input  txBit, erroFrame, overloadFrame, interframe, tec, rec, errorPassive, busOff
  );
endinterface

// File: rtl/error_frame_sequencer.sv
// error_frame_sequencer: sequences CAN error and overload frames (flag, wait for recessive,
// delimiter), maintains TEC/REC and the fault-confinement state, and recovers from bus-off
// after RECOV_RUNS runs of 11 recessive bits.
//   samplePoint : clock, one rising edge per bit sample point
//   reset       : asynchronous active-low reset
//   bus         : error_frame_sequencer_if master modport (strobes in, txBit/flags/counters out)
// All outputs are registered from the next-state values.
module error_frame_sequencer #(
  parameter int unsigned FLAG_LEN   = 6,
  parameter int unsigned DELIM_LEN  = 8,
  parameter int unsigned RECOV_RUNS = 128
) (
  input logic                     samplePoint,
  input logic                     reset,
  error_frame_sequencer_if.master bus
);

  localparam int unsigned RunLen = 11;

  typedef enum logic [2:0] {
    StIdle, StErrFlag, StOvlFlag, StWaitRec, StDelim, StBusOff
  } state_e;

  state_e     r_state, w_state_d;
  logic [3:0] r_bit_cnt, w_bit_cnt_d;
  logic       r_is_ovl, w_is_ovl_d;
  logic       r_flag_passive, w_flag_passive_d;
  logic [8:0] r_tec, w_tec_d;
  logic [7:0] r_rec, w_rec_d;
  logic [3:0] r_run_bits, w_run_bits_d;
  logic [6:0] r_runs, w_runs_d;
  logic       r_tx, r_err_frame, r_ovl_frame, r_interframe, r_err_passive, r_bus_off;
  logic       w_tx_d, w_err_frame_d, w_ovl_frame_d, w_interframe_d;
  logic       w_err_passive_d, w_bus_off_d;
  logic       w_any_err, w_err_entry, w_in_tail;
  logic [3:0] w_delim_bit;

  assign w_any_err = ~(bus.stuffErro & bus.crcErro & bus.eofErro & bus.bitErro);

  always_comb begin
    w_state_d        = r_state;
    w_bit_cnt_d      = r_bit_cnt;
    w_is_ovl_d       = r_is_ovl;
    w_flag_passive_d = r_flag_passive;
    w_tec_d          = r_tec;
    w_rec_d          = r_rec;
    w_run_bits_d     = r_run_bits;
    w_runs_d         = r_runs;
    w_err_entry      = 1'b0;
    w_interframe_d   = 1'b0;
    // Delimiter bit number being sampled on this edge (r_bit_cnt = bits already seen).
    w_delim_bit      = r_bit_cnt + 4'd1;

    unique case (r_state)
      StIdle: begin
        if (w_any_err) begin
          w_err_entry = 1'b1;
        end else begin
          if (bus.frameOk) begin
            if (bus.isTransmitter) begin
              if (r_tec != '0) w_tec_d = r_tec - 9'd1;
            end else if (r_rec > 8'd127) begin
              w_rec_d = 8'd127;
            end else if (r_rec != '0) begin
              w_rec_d = r_rec - 8'd1;
            end
          end
          if (bus.overloadFlag) begin
            w_state_d   = StOvlFlag;
            w_bit_cnt_d = '0;
            w_is_ovl_d  = 1'b1;
          end
        end
      end
      StErrFlag, StOvlFlag: begin
        if (r_bit_cnt == 4'(FLAG_LEN - 1)) begin
          w_state_d = StWaitRec;
        end else begin
          w_bit_cnt_d = r_bit_cnt + 4'd1;
        end
      end
      StWaitRec: begin
        // The first recessive bit after the flag is already delimiter bit 1.
        if (bus.rxBit) begin
          w_state_d   = StDelim;
          w_bit_cnt_d = 4'd1;
        end
      end
      StDelim: begin
        if (w_any_err || (!bus.rxBit && (w_delim_bit < 4'(DELIM_LEN)))) begin
          w_err_entry = 1'b1;  // form error inside the delimiter
        end else if (w_delim_bit == 4'(DELIM_LEN)) begin
          if (!bus.rxBit) begin
            w_state_d   = StOvlFlag;
            w_bit_cnt_d = '0;
            w_is_ovl_d  = 1'b1;
          end else begin
            w_state_d      = StIdle;
            w_interframe_d = 1'b1;
          end
        end else begin
          w_bit_cnt_d = w_delim_bit;
        end
      end
      StBusOff: begin
        if (!bus.rxBit) begin
          w_run_bits_d = '0;
        end else if (r_run_bits == 4'(RunLen - 1)) begin
          w_run_bits_d = '0;
          if (r_runs == 7'(RECOV_RUNS - 1)) begin
            w_state_d = StIdle;
            w_runs_d  = '0;
            w_tec_d   = '0;
            w_rec_d   = '0;
          end else begin
            w_runs_d = r_runs + 7'd1;
          end
        end else begin
          w_run_bits_d = r_run_bits + 4'd1;
        end
      end
      default: w_state_d = StIdle;
    endcase

    if (w_err_entry) begin
      // Flag polarity follows the confinement state in force when the error was detected.
      w_flag_passive_d = r_err_passive;
      w_state_d        = StErrFlag;
      w_bit_cnt_d      = '0;
      w_is_ovl_d       = 1'b0;
      if (bus.isTransmitter) begin
        w_tec_d = r_tec + 9'd8;
        if (w_tec_d >= 9'd256) begin
          w_state_d    = StBusOff;
          w_run_bits_d = '0;
          w_runs_d     = '0;
        end
      end else if (r_rec != 8'hFF) begin
        w_rec_d = r_rec + 8'd1;
      end
    end

    w_in_tail       = (w_state_d == StWaitRec) || (w_state_d == StDelim);
    w_tx_d          = !((w_state_d == StOvlFlag) ||
                        ((w_state_d == StErrFlag) && !w_flag_passive_d));
    w_err_frame_d   = (w_state_d == StErrFlag) || (w_in_tail && !w_is_ovl_d);
    w_ovl_frame_d   = (w_state_d == StOvlFlag) || (w_in_tail && w_is_ovl_d);
    w_bus_off_d     = (w_tec_d >= 9'd256);
    w_err_passive_d = !w_bus_off_d && ((w_tec_d >= 9'd128) || (w_rec_d >= 8'd128));
  end

  always_ff @(posedge samplePoint or negedge reset) begin
    if (!reset) begin
      r_state        <= StIdle;
      r_bit_cnt      <= '0;
      r_is_ovl       <= 1'b0;
      r_flag_passive <= 1'b0;
      r_tec          <= '0;
      r_rec          <= '0;
      r_run_bits     <= '0;
      r_runs         <= '0;
      r_tx           <= 1'b1;
      r_err_frame    <= 1'b0;
      r_ovl_frame    <= 1'b0;
      r_interframe   <= 1'b0;
      r_err_passive  <= 1'b0;
      r_bus_off      <= 1'b0;
    end else begin
      r_state        <= w_state_d;
      r_bit_cnt      <= w_bit_cnt_d;
      r_is_ovl       <= w_is_ovl_d;
      r_flag_passive <= w_flag_passive_d;
      r_tec          <= w_tec_d;
      r_rec          <= w_rec_d;
      r_run_bits     <= w_run_bits_d;
      r_runs         <= w_runs_d;
      r_tx           <= w_tx_d;
      r_err_frame    <= w_err_frame_d;
      r_ovl_frame    <= w_ovl_frame_d;
      r_interframe   <= w_interframe_d;
      r_err_passive  <= w_err_passive_d;
      r_bus_off      <= w_bus_off_d;
    end
  end

  assign bus.txBit         = r_tx;
  assign bus.erroFrame     = r_err_frame;
  assign bus.overloadFrame = r_ovl_frame;
  assign bus.interframe    = r_interframe;
  assign bus.tec           = r_tec;
  assign bus.rec           = r_rec;
  assign bus.errorPassive  = r_err_passive;
  assign bus.busOff        = r_bus_off;

endmodule
